// File: rtl/macu_seq.sv
// Dot-product sequencer that drives one registered macu (co = xi*wi + ci) and saturates to CW bits.
// Optional stall-cycle counter on perf_stall when MACU_SEQ_PERF_EN is defined.
module macu_seq #(
    parameter int DW      = 8,
    parameter int CW      = 16,
    parameter int LW      = 8,
    parameter int MAC_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [LW-1:0] cmd_len,
    input  logic [CW-1:0] cmd_bias,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_x,
    input  logic [DW-1:0] in_w,
    output logic [DW-1:0] mac_xi,
    output logic [DW-1:0] mac_wi,
    output logic [CW-1:0] mac_ci,
    input  logic [CW:0]   mac_co,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] res_data,
    output logic          res_ovf,
`ifdef MACU_SEQ_PERF_EN
    output logic [15:0]   perf_stall,
`endif
    output logic          busy
);

    localparam int WCW = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  acc_q;
    logic [LW-1:0]  rem_q;
    logic [WCW-1:0] wcnt_q;
    logic [WCW-1:0] wcnt_d;
    logic           ovf_q;
    logic           cmd_ready_q;
    logic           res_valid_q;
    logic [CW-1:0]  res_data_q;
    logic           res_ovf_q;

    logic           ret;
    logic           carry;
    logic [CW-1:0]  sat_co;
    logic [CW-1:0]  fb;
    logic           issue;

    // ret marks the cycle in which the single in-flight element is on mac_co.
    assign ret    = (state_q == S_RUN) && (wcnt_q == WCW'(1));
    assign carry  = mac_co[CW];
    assign sat_co = carry ? {CW{1'b1}} : mac_co[CW-1:0];
    assign fb     = ret ? sat_co : acc_q;

    // NOTE: in_ready is decoded from registers only, so it never depends on in_valid.
    assign in_ready = (state_q == S_RUN) && (rem_q != '0) && (wcnt_q <= WCW'(1));
    assign issue    = in_valid && in_ready;

    assign mac_xi = issue ? in_x : '0;
    assign mac_wi = issue ? in_w : '0;
    assign mac_ci = (state_q == S_RUN) ? fb : '0;

    assign busy      = (state_q != S_IDLE);
    assign cmd_ready = cmd_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_ovf   = res_ovf_q;

    always_comb begin
        wcnt_d = wcnt_q;
        if (issue) begin
            wcnt_d = WCW'(MAC_LAT);
        end else if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - WCW'(1);
        end
    end

    // NOTE: every state register is written with <= so all updates land together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            wcnt_q      <= '0;
            ovf_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        acc_q       <= cmd_bias;
                        rem_q       <= cmd_len;
                        ovf_q       <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        if (cmd_len == '0) begin
                            state_q     <= S_DONE;
                            res_data_q  <= cmd_bias;
                            res_ovf_q   <= 1'b0;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        rem_q <= rem_q - LW'(1);
                    end
                    if (ret) begin
                        acc_q <= sat_co;
                        ovf_q <= ovf_q | carry;
                        if (rem_q == '0) begin
                            state_q     <= S_DONE;
                            res_data_q  <= sat_co;
                            res_ovf_q   <= ovf_q | carry;
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef MACU_SEQ_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if ((state_q == S_IDLE) && cmd_valid) begin
            perf_q <= '0;
        end else if (in_ready && !in_valid && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_stall = perf_q;
`endif

endmodule

// File: tb/tb_macu_seq.sv
// Bench for macu_seq: two instances (MAC_LAT=1 and MAC_LAT=3), each with a behavioural macu,
// directed cases followed by random commands checked against an arithmetic dot-product model.
module tb_macu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [7:0]  cmd_len   [2];
    logic [15:0] cmd_bias  [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [7:0]  in_x      [2];
    logic [7:0]  in_w      [2];
    logic [7:0]  mac_xi    [2];
    logic [7:0]  mac_wi    [2];
    logic [15:0] mac_ci    [2];
    logic [16:0] mac_co    [2];
    logic        res_valid [2];
    logic        res_ready [2];
    logic [15:0] res_data  [2];
    logic        res_ovf   [2];
    logic        busy      [2];
`ifdef MACU_SEQ_PERF_EN
    logic [15:0] perf_stall [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [16:0] pipe [LAT];

        // Behavioural macu: co appears LAT edges after the operands are sampled.
        always @(posedge clk) begin
            pipe[0] <= 17'(mac_xi[g]) * 17'(mac_wi[g]) + 17'(mac_ci[g]);
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign mac_co[g] = pipe[LAT-1];

        macu_seq #(.DW(8), .CW(16), .LW(8), .MAC_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_len   (cmd_len[g]),
            .cmd_bias  (cmd_bias[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_x      (in_x[g]),
            .in_w      (in_w[g]),
            .mac_xi    (mac_xi[g]),
            .mac_wi    (mac_wi[g]),
            .mac_ci    (mac_ci[g]),
            .mac_co    (mac_co[g]),
            .res_valid (res_valid[g]),
            .res_ready (res_ready[g]),
            .res_data  (res_data[g]),
            .res_ovf   (res_ovf[g]),
`ifdef MACU_SEQ_PERF_EN
            .perf_stall(perf_stall[g]),
`endif
            .busy      (busy[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cyc, res_cyc, n_issue, first_iss, last_iss, min_gap;
    logic [7:0] px [$];
    logic [7:0] pw [$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: bias plus sum of products, clamped to 16 bits after every element.
    function automatic logic [16:0] ref_dot(input logic [15:0] bias, input int len);
        int unsigned acc;
        logic        ovf;
        acc = 32'(bias);
        ovf = 1'b0;
        for (int i = 0; i < len; i++) begin
            acc = acc + int'(px[i]) * int'(pw[i]);
            if (acc > 32'd65535) begin
                acc = 32'd65535;
                ovf = 1'b1;
            end
        end
        return {ovf, acc[15:0]};
    endfunction

    task automatic do_cmd(input int u, input int len, input logic [15:0] bias, input int gap_at,
                          input int gap_len, input int rnd_gap, input int hold, input string tag);
        int t, idx, gcnt;
        logic [16:0] exp;
        exp = ref_dot(bias, len);
        t = 0;
        while (cmd_ready[u] !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        check({tag, "_cmd_ready"}, 32'(cmd_ready[u]), 1);
        cmd_valid[u] = 1'b1;
        cmd_len[u]   = 8'(len);
        cmd_bias[u]  = bias;
        tick();
        cmd_valid[u] = 1'b0;
        cmd_len[u]   = 8'($urandom);
        cmd_bias[u]  = 16'($urandom);
        acc_cyc = cyc; idx = 0; gcnt = 0; n_issue = 0;
        first_iss = -1; last_iss = -1000; min_gap = 1000; t = 0;
        while (res_valid[u] !== 1'b1 && t < 300) begin
            if (idx < len && idx == gap_at && gcnt < gap_len) begin
                in_valid[u] = 1'b0;
                gcnt++;
            end else if (idx < len) begin
                in_valid[u] = (rnd_gap == 0) || ($urandom_range(0, 2) != 0);
                in_x[u] = px[idx];
                in_w[u] = pw[idx];
            end else begin
                in_valid[u] = 1'($urandom_range(0, 1));
                in_x[u] = 8'($urandom);
                in_w[u] = 8'($urandom);
            end
            if (in_valid[u] && in_ready[u]) begin
                if (first_iss < 0) first_iss = cyc;
                if (cyc - last_iss < min_gap) min_gap = cyc - last_iss;
                last_iss = cyc;
                n_issue++;
                idx++;
            end
            tick();
            t++;
        end
        in_valid[u] = 1'b0;
        res_cyc = cyc;
        check({tag, "_res_valid"}, 32'(res_valid[u]), 1);
        check({tag, "_issued"}, n_issue, len);
        for (int k = 0; k < hold; k++) begin
            tick();
            check({tag, "_hold_data"}, 32'(res_data[u]), 32'(exp[15:0]));
            check({tag, "_hold_cmd_ready"}, 32'(cmd_ready[u]), 0);
        end
        res_ready[u] = 1'b1;
        check({tag, "_res_data"}, 32'(res_data[u]), 32'(exp[15:0]));
        check({tag, "_res_ovf"}, 32'(res_ovf[u]), 32'(exp[16]));
        tick();
        res_ready[u] = 1'b0;
        check({tag, "_res_valid_drop"}, 32'(res_valid[u]), 0);
        check({tag, "_cmd_ready_back"}, 32'(cmd_ready[u]), 1);
        check({tag, "_idle"}, 32'(busy[u]), 0);
    endtask

    initial begin
        int len;
        logic [15:0] bias;
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            cmd_valid[u] = 1'b0; cmd_len[u] = '0; cmd_bias[u] = '0;
            in_valid[u] = 1'b0; in_x[u] = '0; in_w[u] = '0; res_ready[u] = 1'b0;
        end
        repeat (3) tick();
        rst = 1'b0;

        for (int u = 0; u < 2; u++) begin
            check("rst_cmd_ready", 32'(cmd_ready[u]), 1);
            check("rst_in_ready", 32'(in_ready[u]), 0);
            check("rst_res_valid", 32'(res_valid[u]), 0);
            check("rst_res_data", 32'(res_data[u]), 0);
            check("rst_res_ovf", 32'(res_ovf[u]), 0);
            check("rst_busy", 32'(busy[u]), 0);
            check("rst_mac_ci", 32'(mac_ci[u]), 0);
            check("rst_mac_xi", 32'(mac_xi[u]), 0);
        end

        px = '{8'd1, 8'd2, 8'd3}; pw = '{8'd1, 8'd1, 8'd1};
        do_cmd(0, 3, 16'd0, -1, 0, 0, 0, "b2b");
        check("b2b_latency", res_cyc - acc_cyc, 4);
        check("b2b_first_issue", first_iss - acc_cyc, 0);
        check("b2b_span", last_iss - first_iss, 2);

        px.delete(); pw.delete();
        do_cmd(0, 0, 16'h1234, -1, 0, 0, 0, "zero");
        check("zero_latency", res_cyc - acc_cyc, 0);

        px = '{8'd255, 8'd1}; pw = '{8'd255, 8'd1};
        do_cmd(0, 2, 16'hFF00, -1, 0, 0, 0, "ovf");
        px = '{8'd2}; pw = '{8'd3};
        do_cmd(0, 1, 16'd0, -1, 0, 0, 0, "ovf_clear");

        px = '{8'd16, 8'd2}; pw = '{8'd100, 8'd2};
        do_cmd(0, 2, 16'd10, 1, 3, 0, 5, "bp");
`ifdef MACU_SEQ_PERF_EN
        check("bp_perf_stall", 32'(perf_stall[0]), 3);
`endif

        do_cmd(1, 2, 16'd10, 1, 3, 0, 5, "lat3_bp");
        check("lat3_bp_gap", 32'(min_gap >= 3), 1);
        px = '{8'd1, 8'd2, 8'd3}; pw = '{8'd1, 8'd1, 8'd1};
        do_cmd(1, 3, 16'd0, -1, 0, 0, 0, "lat3_b2b");
        check("lat3_b2b_gap", min_gap, 3);

        cmd_valid[0] = 1'b1; cmd_len[0] = 8'd3; cmd_bias[0] = 16'd0;
        tick();
        cmd_valid[0] = 1'b0;
        in_valid[0] = 1'b1; in_x[0] = 8'd7; in_w[0] = 8'd8;
        check("mr_in_ready", 32'(in_ready[0]), 1);
        tick();
        in_valid[0] = 1'b0;
        check("mr_busy_pre", 32'(busy[0]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_busy", 32'(busy[0]), 0);
        check("mr_res_valid", 32'(res_valid[0]), 0);
        check("mr_cmd_ready", 32'(cmd_ready[0]), 1);
        check("mr_in_ready_post", 32'(in_ready[0]), 0);
        px = '{8'd4}; pw = '{8'd5};
        do_cmd(0, 1, 16'd0, -1, 0, 0, 0, "after_rst");

        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 8; n++) begin
                len = $urandom_range(0, 6);
                bias = ($urandom_range(0, 1) != 0) ? (16'hF000 | 16'($urandom)) : 16'($urandom_range(0, 4095));
                px.delete(); pw.delete();
                for (int i = 0; i < len; i++) begin
                    px.push_back(8'($urandom));
                    pw.push_back(8'($urandom));
                end
                do_cmd(u, len, bias, -1, 0, 1, $urandom_range(0, 3), "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
